// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT    = 2'b01,
    RELEASE = 2'b10
  } mem_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch-flush / data-memory freeze controller for the 5-stage pipeline,
// plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [REG_ADDR_W-1:0] ID_RS1addr_i,
  input  logic [REG_ADDR_W-1:0] ID_RS2addr_i,
  input  logic                  EX_MemRead_i,
  input  logic [REG_ADDR_W-1:0] EX_RDaddr_i,
  input  logic                  Branch_taken_i,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic                  dmem_ack_i,
  output logic                  dmem_req_o,
  output logic                  PCWrite_o,
  output logic                  IF_ID_Write_o,
  output logic                  NoOp_o,
  output logic                  Flush_o,
  output logic                  Stall_all_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  mem_state_e state_q, state_d;
  logic       mem_stall;
  logic       hz;
  logic       stall_g, hz_g;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= RUN;
    else          state_q <= state_d;
  end

  // RELEASE is a one-cycle gap so the same MEM instruction is not reissued.
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    unique case (state_q)
      RUN: begin
        if (MEM_MemRead_i || MEM_MemWrite_i) begin
          mem_stall = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (dmem_ack_i) state_d = RELEASE;
      end
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign hz = EX_MemRead_i && (EX_RDaddr_i != REG_ADDR_W'(REG_X0)) &&
              ((EX_RDaddr_i == ID_RS1addr_i) || (EX_RDaddr_i == ID_RS2addr_i));

  // Outputs are forced to their idle values for as long as reset is held.
  assign stall_g = rst_n_i && mem_stall;
  assign hz_g    = rst_n_i && hz;

  always_comb begin
    dmem_req_o    = stall_g;
    Stall_all_o   = stall_g;
    PCWrite_o     = 1'b1;
    IF_ID_Write_o = 1'b1;
    NoOp_o        = 1'b0;
    Flush_o       = 1'b0;
    if (stall_g) begin
      PCWrite_o     = 1'b0;
      IF_ID_Write_o = 1'b0;
    end else if (hz_g) begin
      PCWrite_o     = 1'b0;
      IF_ID_Write_o = 1'b0;
      NoOp_o        = 1'b1;
    end else if (rst_n_i && Branch_taken_i) begin
      Flush_o = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (stall_g || hz_g),
    .cnt_o   (stall_cnt_o)
  );

endmodule
